// File: rtl/uart_pkg.sv
// Shared definitions for the ThinPad UART controller: state codes, default
// register addresses and status-word bit positions.
package uart_pkg;

  localparam logic [15:0] DEF_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] DEF_STAT_ADDR = 16'hBF01;

  localparam int STAT_TX_RDY_BIT = 0;
  localparam int STAT_RX_RDY_BIT = 1;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_RD_LOW    = 4'd1;
  localparam logic [3:0] ST_RD_CAP    = 4'd2;
  localparam logic [3:0] ST_WR_SETUP  = 4'd3;
  localparam logic [3:0] ST_WR_LOW    = 4'd4;
  localparam logic [3:0] ST_WR_HIGH   = 4'd5;
  localparam logic [3:0] ST_WAIT_TBRE = 4'd6;
  localparam logic [3:0] ST_WAIT_TSRE = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE      = ST_IDLE,
    S_RD_LOW    = ST_RD_LOW,
    S_RD_CAP    = ST_RD_CAP,
    S_WR_SETUP  = ST_WR_SETUP,
    S_WR_LOW    = ST_WR_LOW,
    S_WR_HIGH   = ST_WR_HIGH,
    S_WAIT_TBRE = ST_WAIT_TBRE,
    S_WAIT_TSRE = ST_WAIT_TSRE,
    S_DONE      = ST_DONE
  } uart_state_e;

  function automatic logic [15:0] status_word(input logic rx_rdy, input logic tx_rdy);
    logic [15:0] w_word;
    w_word = '0;
    w_word[STAT_RX_RDY_BIT] = rx_rdy;
    w_word[STAT_TX_RDY_BIT] = tx_rdy;
    return w_word;
  endfunction

endpackage

// File: rtl/uart_wait_timer.sv
// Wait-state counter: clears on i_clr, counts on i_inc, and flags the cycle
// in which the count would reach LIMIT.
module uart_wait_timer #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_term
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != W'(LIMIT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Terminal in the wait cycle whose increment lands on LIMIT.
  assign o_term = i_inc && (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/uart_ctrl.sv
// ThinPad memory-stage UART controller: address decode, rdn/wrn handshake and
// no_stop pipeline stall. Define UART_TIMEOUT_EN to bound the transmit waits.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter logic [15:0] DATA_ADDR      = DEF_DATA_ADDR,
  parameter logic [15:0] STAT_ADDR      = DEF_STAT_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        hit,
  output logic [15:0] rdata,
  output logic        no_stop,
  input  logic [7:0]  ser_data_in,
  output logic [7:0]  ser_data_out,
  output logic        ser_data_oe,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic        timeout_err
);

  uart_state_e r_state;
  uart_state_e w_state_next;

  logic       r_rdn;
  logic       r_wrn;
  logic       r_oe;
  logic       r_no_stop;
  logic       r_is_rd;
  logic [7:0] r_out;
  logic [7:0] r_cap;

  logic w_data_hit;
  logic w_stat_hit;
  logic w_wr_req;
  logic w_rd_req;
  logic w_stat_rd;
  logic w_tmo;

  assign w_data_hit = (addr == DATA_ADDR);
  assign w_stat_hit = (addr == STAT_ADDR);
  assign hit        = w_data_hit | w_stat_hit;

  // A simultaneous read and write on a serial address is a write.
  assign w_wr_req  = mem_write & w_data_hit;
  assign w_rd_req  = mem_read & ~mem_write & w_data_hit;
  assign w_stat_rd = mem_read & ~mem_write & w_stat_hit;

`ifdef UART_TIMEOUT_EN
  logic w_tmr_clr;
  logic w_tmr_inc;
  logic w_set_err;
  logic r_timeout_err;

  assign w_tmr_clr = (r_state == S_WR_HIGH);
  assign w_tmr_inc = (r_state == S_WAIT_TBRE) | (r_state == S_WAIT_TSRE);

  uart_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tmr_clr),
    .i_inc  (w_tmr_inc),
    .o_term (w_tmo)
  );

  // A handshake completing on the terminal cycle still counts as success.
  assign w_set_err = w_tmo & (((r_state == S_WAIT_TBRE) & ~tbre) |
                              ((r_state == S_WAIT_TSRE) & ~tsre));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_set_err) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_wr_req) begin
          w_state_next = S_WR_SETUP;
        end else if (w_rd_req) begin
          w_state_next = S_RD_LOW;
        end
      end
      S_RD_LOW:   w_state_next = S_RD_CAP;
      S_RD_CAP:   w_state_next = S_DONE;
      S_WR_SETUP: w_state_next = S_WR_LOW;
      S_WR_LOW:   w_state_next = S_WR_HIGH;
      S_WR_HIGH:  w_state_next = S_WAIT_TBRE;
      S_WAIT_TBRE: begin
        if (tbre) begin
          w_state_next = S_WAIT_TSRE;
        end else if (w_tmo) begin
          w_state_next = S_DONE;
        end
      end
      S_WAIT_TSRE: begin
        if (tsre || w_tmo) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Strobes and stall are registered from the next state so they only move on edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdn     <= 1'b1;
      r_wrn     <= 1'b1;
      r_oe      <= 1'b0;
      r_no_stop <= 1'b1;
      r_out     <= 8'h00;
      r_cap     <= 8'h00;
      r_is_rd   <= 1'b0;
    end else begin
      r_rdn     <= ~((w_state_next == S_RD_LOW) | (w_state_next == S_RD_CAP));
      r_wrn     <= ~(w_state_next == S_WR_LOW);
      r_oe      <= (w_state_next == S_WR_SETUP) | (w_state_next == S_WR_LOW) |
                   (w_state_next == S_WR_HIGH);
      r_no_stop <= (w_state_next == S_IDLE) | (w_state_next == S_DONE);
      if ((r_state == S_IDLE) && (w_state_next == S_WR_SETUP)) begin
        r_out <= wdata[7:0];
      end
      if (r_state == S_RD_CAP) begin
        r_cap <= ser_data_in;
      end
      if (r_state == S_IDLE) begin
        r_is_rd <= (w_state_next == S_RD_LOW);
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (w_stat_rd) begin
      rdata = status_word(data_ready, tbre & tsre & (r_state == S_IDLE));
    end else if ((r_state == S_DONE) && r_is_rd) begin
      rdata = {8'h00, r_cap};
    end
  end

  assign rdn          = r_rdn;
  assign wrn          = r_wrn;
  assign ser_data_oe  = r_oe;
  assign ser_data_out = r_out;
  assign no_stop      = r_no_stop;

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: per-cycle expectations from a
// transaction-level timeline model, plus literal checks from the test plan.
module tb_uart_ctrl;

  localparam logic [15:0] DADDR = 16'hBF00;
  localparam logic [15:0] SADDR = 16'hBF01;
  localparam int          TMO   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        hit;
  logic [15:0] rdata;
  logic        no_stop;
  logic [7:0]  ser_data_in;
  logic [7:0]  ser_data_out;
  logic        ser_data_oe;
  logic        rdn;
  logic        wrn;
  logic        data_ready;
  logic        tbre;
  logic        tsre;
  logic        timeout_err;

  always #5 clk = ~clk;

  uart_ctrl #(
    .DATA_ADDR      (DADDR),
    .STAT_ADDR      (SADDR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .wdata        (wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .hit          (hit),
    .rdata        (rdata),
    .no_stop      (no_stop),
    .ser_data_in  (ser_data_in),
    .ser_data_out (ser_data_out),
    .ser_data_oe  (ser_data_oe),
    .rdn          (rdn),
    .wrn          (wrn),
    .data_ready   (data_ready),
    .tbre         (tbre),
    .tsre         (tsre),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
    logic [7:0]  sin;
    logic        dr;
    logic        tbre;
    logic        tsre;
  } stim_t;

  typedef struct {
    logic        hit;
    logic [15:0] rdata;
    logic        ns;
    logic        rdn;
    logic        wrn;
    logic        oe;
    logic        chk_out;
    logic [7:0]  out;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic m_err = 1'b0;
  int   ns_low_cnt = 0;
  int   rdn_low_cnt = 0;
  int   wrn_low_cnt = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model timeline, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!no_stop) ns_low_cnt++;
      if (!rdn) rdn_low_cnt++;
      if (!wrn) wrn_low_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hit", 16'(hit), 16'(e.hit));
        chk("rdata", rdata, e.rdata);
        chk("no_stop", 16'(no_stop), 16'(e.ns));
        chk("rdn", 16'(rdn), 16'(e.rdn));
        chk("wrn", 16'(wrn), 16'(e.wrn));
        chk("ser_data_oe", 16'(ser_data_oe), 16'(e.oe));
        chk("timeout_err", 16'(timeout_err), 16'(e.err));
        if (e.chk_out) chk("ser_data_out", 16'(ser_data_out), 16'(e.out));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic stim_t bg();
    stim_t s;
    s.rst   = 1'b1;
    s.addr  = 16'($urandom_range(0, 32'hBEFF));
    s.wdata = 16'($urandom);
    s.rd    = 1'($urandom);
    s.wr    = 1'($urandom);
    s.sin   = 8'($urandom);
    s.dr    = 1'($urandom);
    s.tbre  = 1'($urandom);
    s.tsre  = 1'($urandom);
    return s;
  endfunction

  function automatic exp_t ex(input logic h, input logic [15:0] rd_v, input logic ns_v,
                              input logic rdn_v, input logic wrn_v, input logic oe_v,
                              input logic [7:0] out_v);
    exp_t e;
    e.hit = h; e.rdata = rd_v; e.ns = ns_v; e.rdn = rdn_v; e.wrn = wrn_v;
    e.oe = oe_v; e.chk_out = oe_v; e.out = out_v; e.err = m_err;
    return e;
  endfunction

  task automatic step(input stim_t s, input exp_t e);
    @(posedge clk); #1;
    rst = s.rst; addr = s.addr; wdata = s.wdata; mem_read = s.rd; mem_write = s.wr;
    ser_data_in = s.sin; data_ready = s.dr; tbre = s.tbre; tsre = s.tsre;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_idle();
    step(bg(), ex(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0));
  endtask

  task automatic do_status(input logic dr, input logic tb, input logic ts);
    stim_t s = bg();
    s.addr = SADDR; s.rd = 1'b1; s.wr = 1'b0; s.dr = dr; s.tbre = tb; s.tsre = ts;
    step(s, ex(1'b1, {14'b0, dr, tb & ts}, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0));
  endtask

  task automatic do_stat_write();
    stim_t s = bg();
    s.addr = SADDR; s.wr = 1'b1;
    step(s, ex(1'b1, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0));
  endtask

  // Read timeline: request seen in IDLE, two strobe cycles, then DONE with the byte.
  task automatic do_read(input logic [7:0] b);
    stim_t s = bg();
    s.addr = DADDR; s.rd = 1'b1; s.wr = 1'b0;
    step(s, ex(1'b1, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0));
    s.sin = 8'($urandom); s.dr = 1'($urandom);
    step(s, ex(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0));
    s.sin = b;
    step(s, ex(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0));
    s.sin = 8'($urandom);
    step(s, ex(1'b1, {8'h00, b}, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0));
  endtask

  // Write timeline: 3 drive cycles, k1 extra tbre waits, k2 extra tsre waits.
  // With tmo set, tsre never rises and the wait window totals TMO cycles.
  task automatic do_write(input logic [15:0] wd, input logic both, input int k1,
                          input int k2, input logic tmo);
    stim_t s = bg();
    logic [7:0] b = wd[7:0];
    int ntsre;
    s.addr = DADDR; s.wr = 1'b1; s.rd = both; s.wdata = wd;
    step(s, ex(1'b1, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0));
    step(s, ex(1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, b));
    step(s, ex(1'b1, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, b));
    step(s, ex(1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, b));
    for (int i = 0; i <= k1; i++) begin
      s.tbre = (i == k1); s.tsre = 1'($urandom);
      step(s, ex(1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0));
    end
    ntsre = tmo ? (TMO - k1 - 1) : (k2 + 1);
    for (int i = 0; i < ntsre; i++) begin
      s.tsre = tmo ? 1'b0 : (i == k2); s.tbre = 1'($urandom);
      step(s, ex(1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0));
    end
    if (tmo) m_err = 1'b1;
    s.tsre = 1'($urandom);
    step(s, ex(1'b1, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0));
  endtask

  // Reset lands while waiting on tsre; the following cycle must be a clean IDLE.
  task automatic do_reset_mid();
    stim_t s = bg();
    exp_t e;
    s.addr = DADDR; s.wr = 1'b1; s.rd = 1'b0; s.wdata = 16'h00C3;
    step(s, ex(1'b1, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0));
    step(s, ex(1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3));
    step(s, ex(1'b1, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC3));
    step(s, ex(1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3));
    s.tbre = 1'b1; s.tsre = 1'b0;
    step(s, ex(1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0));
    step(s, ex(1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0));
    s.rst = 1'b0;
    step(s, ex(1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0));
    m_err = 1'b0;
    e = ex(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0);
    e.chk_out = 1'b1;
    step(bg(), e);
  endtask

  task automatic do_random();
    int op = $urandom_range(0, 5);
    case (op)
      0: do_status(1'($urandom), 1'($urandom), 1'($urandom));
      1: do_read(8'($urandom));
      2: do_write(16'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
      3: do_stat_write();
      default: do_idle();
    endcase
  endtask

  initial begin
    exp_t e;
    int ns0, rdn0, wrn0;
    rst = 1'b0; addr = 16'h0; wdata = 16'h0; mem_read = 1'b0; mem_write = 1'b0;
    ser_data_in = 8'h0; data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
    repeat (2) @(posedge clk);

    e = ex(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0);
    e.chk_out = 1'b1;
    step(bg(), e);

    do_status(1'b1, 1'b1, 1'b1);
    settle();
    chk("status_literal", rdata, 16'h0003);
    chk("status_no_stop", 16'(no_stop), 16'h1);
    do_idle();

    ns0 = ns_low_cnt; rdn0 = rdn_low_cnt;
    do_read(8'hA5);
    settle();
    chk("read_literal", rdata, 16'h00A5);
    chk("read_rdn_cycles", 16'(rdn_low_cnt - rdn0), 16'd2);
    chk("read_stall_cycles", 16'(ns_low_cnt - ns0), 16'd2);
    do_idle();

    ns0 = ns_low_cnt; wrn0 = wrn_low_cnt;
    do_write(16'h1234, 1'b0, 3, 0, 1'b0);
    settle();
    chk("write_stall_cycles", 16'(ns_low_cnt - ns0), 16'd8);
    chk("write_wrn_cycles", 16'(wrn_low_cnt - wrn0), 16'd1);
    do_idle();

    rdn0 = rdn_low_cnt;
    do_write(16'h5A77, 1'b1, 0, 0, 1'b0);
    settle();
    chk("both_rdn_cycles", 16'(rdn_low_cnt - rdn0), 16'd0);
    do_stat_write();
    do_idle();

    for (int i = 0; i < 80; i++) do_random();
    do_idle();

`ifdef UART_TIMEOUT_EN
    ns0 = ns_low_cnt;
    do_write(16'h00EE, 1'b0, 0, 0, 1'b1);
    settle();
    chk("timeout_flag", 16'(timeout_err), 16'h1);
    chk("timeout_stall_cycles", 16'(ns_low_cnt - ns0), 16'(3 + TMO));
    repeat (3) do_idle();
    settle();
    chk("timeout_sticky", 16'(timeout_err), 16'h1);
`endif

    do_reset_mid();
    settle();
    chk("rst_no_stop", 16'(no_stop), 16'h1);
    chk("rst_oe", 16'(ser_data_oe), 16'h0);
    chk("rst_strobes", {14'b0, rdn, wrn}, 16'h0003);
    chk("rst_timeout_err", 16'(timeout_err), 16'h0);

    for (int i = 0; i < 30; i++) do_random();
    do_idle();
    settle();
    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Serial-port access controller for the memory stage of the ThinPad pipeline. It decodes loads and stores to the UART data and status addresses. It runs the `rdn`/`wrn`/`data_ready`/`tbre`/`tsre` handshake on the shared low data byte. While a transfer is in flight it holds `no_stop` low, which gates the pipeline clock.

## Interface

Parameters:
- `DATA_ADDR`, default 16'hBF00: UART data register address.
- `STAT_ADDR`, default 16'hBF01: UART status register address.
- `TIMEOUT_CYCLES`, default 1023: wait-state limit, used only with `UART_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock. Every register is on its rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `addr` in 16: memory-stage address.
- `wdata` in 16: store data. Only bits [7:0] are transmitted.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `hit` out 1: combinational; `addr` equals `DATA_ADDR` or `STAT_ADDR`.
- `rdata` out 16: load result.
- `no_stop` out 1: 1 means the pipeline may advance; 0 stalls it.
- `ser_data_in` in 8: sampled serial data bus.
- `ser_data_out` out 8: driven serial data.
- `ser_data_oe` out 1: tri-state enable for `ser_data_out`.
- `rdn` out 1: UART read strobe, active-low.
- `wrn` out 1: UART write strobe, active-low.
- `data_ready` in 1: UART has a received byte.
- `tbre` in 1: transmit buffer empty.
- `tsre` in 1: transmit shift register empty.
- `timeout_err` out 1: sticky handshake timeout flag.

## Operation

States: IDLE, RD_LOW, RD_CAP, WR_SETUP, WR_LOW, WR_HIGH, WAIT_TBRE, WAIT_TSRE, DONE.

Reset values (`rst`=0 at an edge): state=IDLE, `rdn`=1, `wrn`=1, `ser_data_oe`=0, `ser_data_out`=0, capture register=0, `timeout_err`=0. `no_stop`=1 whenever the state is IDLE or DONE. A reset mid-transfer aborts it in the same edge.

Status read (`mem_read`, `addr`=`STAT_ADDR`):
- Combinational; no stall.
- `rdata` = {14'b0, `data_ready`, `tbre` & `tsre` & (state==IDLE)}.

Data read (`mem_read`, `addr`=`DATA_ADDR`):
- Transitions: IDLE → RD_LOW → RD_CAP → DONE → IDLE.
- RD_LOW: `rdn`=0.
- RD_CAP: `rdn`=0; `ser_data_in` is captured at the end of this cycle.
- DONE: `rdn`=1; `rdata` = {8'h00, captured byte}.
- The read proceeds even if `data_ready`=0; software polls status first.

Data write (`mem_write`, `addr`=`DATA_ADDR`):
- Transitions: IDLE → WR_SETUP → WR_LOW → WR_HIGH → WAIT_TBRE → WAIT_TSRE → DONE → IDLE.
- `ser_data_oe`=1 and `ser_data_out`=`wdata[7:0]` from WR_SETUP through WR_HIGH.
- `wrn`=0 only in WR_LOW.
- WAIT_TBRE exits when `tbre`=1; WAIT_TSRE exits when `tsre`=1.

Other rules:
- `rdata`=0 when no serial load is active.
- `mem_read` and `mem_write` both high on a serial address: treated as a write.
- Writes to `STAT_ADDR` are ignored, with no stall.
- DONE always returns to IDLE. A request still present in the cycle after DONE starts a new transfer; the pipeline has already advanced by then.

## Timing

- Status read: 0 stall cycles.
- Data read: `no_stop` low for 2 cycles (RD_LOW, RD_CAP). DONE is the advancing cycle.
- Data write: `no_stop` low for at least 5 cycles, when `tbre`=`tsre`=1 on entry to each wait state. Each cycle a wait condition stays low adds one stall cycle.
- `no_stop` is registered-state decoded and glitch-free: it changes only on `clk` edges and is never a function of request inputs.
- `hit` and the status `rdata` are combinational from `addr`, `mem_read`, `data_ready`, `tbre` and `tsre`.

## Configuration

`UART_TIMEOUT_EN`:
- Defined: a counter clears on entering WAIT_TBRE and increments in both wait states. When it reaches `TIMEOUT_CYCLES`, the FSM goes to DONE and sets `timeout_err`. The flag stays set until reset.
- Undefined: the wait states block indefinitely and `timeout_err` is tied to 0. The port list is identical in both builds.

## Structure

- Shared package `uart_pkg`: state encoding localparams (4 bits), `DATA_ADDR`/`STAT_ADDR` defaults and status bit indices (0 = tx ready, 1 = rx ready).
- One sub-module, `uart_wait_timer`: clear/increment counter with terminal flag, instantiated only under `UART_TIMEOUT_EN`.

## Test plan

- Reset, then status read with `data_ready`=1, `tbre`=`tsre`=1 → `rdata`=16'h0003, `no_stop` stays 1.
- Data read with `ser_data_in`=8'hA5 → `rdn` low for 2 cycles, `no_stop` low for 2 cycles, DONE `rdata`=16'h00A5.
- Store 16'h1234 with `tbre` low for 3 extra cycles → `ser_data_out`=8'h34, `wrn` low exactly 1 cycle, `no_stop` low for 8 cycles.
- Reset asserted during WAIT_TSRE → next edge: IDLE, `rdn`=`wrn`=1, `ser_data_oe`=0, `no_stop`=1.
- `UART_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `tsre` stuck 0 → DONE after 8 wait cycles, `timeout_err`=1 and held until reset.
- `mem_read` and `mem_write` both high at `DATA_ADDR` → write sequence runs and `rdn` never asserts.
